// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor.
// Each stage adds one SLICE-bit slice of the operands plus the carry from the
// previous slice. The unused high operand bits travel down the pipeline with
// the partial sum, so no combinational path spans more than one slice.
// A valid/ready handshake stalls the whole pipeline when the output is full
// and the consumer is not taking it.
module pipelined_addsub #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             addsub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSTAGE = (WIDTH + SLICE - 1) / SLICE;
  localparam int LAST   = NSTAGE - 1;

  // Global advance: the pipeline moves only when the output slot is free or
  // is being drained this cycle.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage k holds the operand bits that are not yet added (bit 0 of a_q/b_q
  // is bit k*SLICE of the original operand), the carry into slice k and the
  // sum bits already produced by earlier slices.
  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int LO  = k * SLICE;
    localparam int REM = WIDTH - LO;
    localparam int SW  = (REM < SLICE) ? REM : SLICE;

    logic           v_q;
    logic           c_q;
    logic           sa_q;
    logic           sb_q;
    logic [REM-1:0] a_q;
    logic [REM-1:0] b_q;
    logic [SW:0]    tot;
    logic           c_out;
    logic [LO+SW-1:0] s_acc;

    // Slice adder: the only combinational arithmetic between two registers.
    assign tot   = {1'b0, a_q[SW-1:0]} + {1'b0, b_q[SW-1:0]} + {{SW{1'b0}}, c_q};
    assign c_out = tot[SW];

    if (k == 0) begin : g_first
      // Stage-0 valid bit: set by an accepted operand, cleared by a bubble.
      always_ff @(posedge clk or negedge nrst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!nrst)   v_q <= 1'b0;
        else if (en) v_q <= in_valid;
      end

      // Operand capture; B is inverted and carry-in set for subtraction.
      always_ff @(posedge clk) begin
        // NOTE: datapath registers carry no reset; their contents are only
        // ever observed when qualified by a valid bit that is reset.
        if (en && in_valid) begin
          a_q  <= a;
          b_q  <= b ^ {WIDTH{addsub}};
          c_q  <= addsub;
          sa_q <= a[WIDTH-1];
          sb_q <= b[WIDTH-1] ^ addsub;
        end
      end

      assign s_acc = tot[SW-1:0];
    end else begin : g_next
      logic [LO-1:0] s_q;

      // Valid bit follows the previous stage.
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)   v_q <= 1'b0;
        else if (en) v_q <= g_stage[k-1].v_q;
      end

      // Shift remaining operands, carry and partial sum from the previous stage.
      always_ff @(posedge clk) begin
        if (en) begin
          a_q  <= g_stage[k-1].a_q[SLICE +: REM];
          b_q  <= g_stage[k-1].b_q[SLICE +: REM];
          c_q  <= g_stage[k-1].c_out;
          s_q  <= g_stage[k-1].s_acc;
          sa_q <= g_stage[k-1].sa_q;
          sb_q <= g_stage[k-1].sb_q;
        end
      end

      assign s_acc = {tot[SW-1:0], s_q};
    end
  end

  logic [WIDTH-1:0] fin_sum;
  logic             fin_sa;
  logic             fin_sb;
  assign fin_sum = g_stage[LAST].s_acc;
  assign fin_sa  = g_stage[LAST].sa_q;
  assign fin_sb  = g_stage[LAST].sb_q;

  // Output registers: load a finished result when advancing; hold otherwise,
  // and keep the last result visible while no valid one replaces it.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (en) begin
      out_valid <= g_stage[LAST].v_q;
      if (g_stage[LAST].v_q) begin
        sum  <= fin_sum;
        cout <= g_stage[LAST].c_out;
        ovf  <= (fin_sa == fin_sb) && (fin_sum[WIDTH-1] != fin_sa);
        zero <= (fin_sum == '0);
      end
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: an 8/2 instance (4 stages) and a
// 7/3 instance (3 stages). A reference model pushes expected results into a
// queue when an operand is accepted; a monitor compares the queue front with
// the output whenever out_valid is high and pops on consumption.
module tb_pipelined_addsub;

  localparam int NS_A = 4;
  localparam int NS_B = 3;

  typedef struct {
    logic [10:0] exp;
    int          t;
  } sb_t;

  logic clk = 1'b0;
  logic nrst;

  logic       a_in_valid, a_in_ready, a_addsub, a_out_valid, a_out_ready;
  logic [7:0] a_a, a_b, a_sum;
  logic       a_cout, a_ovf, a_zero;

  logic       b_in_valid, b_in_ready, b_addsub, b_out_valid, b_out_ready;
  logic [6:0] b_a, b_b, b_sum;
  logic       b_cout, b_ovf, b_zero;

  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc = 0;
  bit  chk_lat = 1'b1;
  bit  rnd_on  = 1'b0;
  sb_t q_a[$];
  sb_t q_b[$];

  pipelined_addsub #(.WIDTH(8), .SLICE(2)) u_dut_a (
    .clk(clk), .nrst(nrst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .addsub(a_addsub), .a(a_a), .b(a_b), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .sum(a_sum), .cout(a_cout), .ovf(a_ovf), .zero(a_zero)
  );

  pipelined_addsub #(.WIDTH(7), .SLICE(3)) u_dut_b (
    .clk(clk), .nrst(nrst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .addsub(b_addsub), .a(b_a), .b(b_b), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .sum(b_sum), .cout(b_cout), .ovf(b_ovf), .zero(b_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: returns {zero, ovf, cout, sum[7:0]} for a w-bit operation.
  function automatic logic [10:0] model(int w, logic [7:0] x, logic [7:0] y, logic sub);
    logic [8:0] mask, bb, t;
    logic [7:0] s;
    logic       c, o, z, sa, sb;
    mask = 9'((1 << w) - 1);
    bb   = sub ? (~{1'b0, y} & mask) : {1'b0, y};
    t    = {1'b0, x} + bb + {8'd0, sub};
    s    = t[7:0] & mask[7:0];
    c    = t[w];
    sa   = x[w-1];
    sb   = bb[w-1];
    o    = (sa == sb) && (s[w-1] != sa);
    z    = (s == 8'd0);
    return {z, o, c, s};
  endfunction

  // Scoreboard monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (!nrst) begin
      q_a.delete();
    end else begin
      if (a_out_valid) begin
        if (q_a.size() == 0) begin
          check("A_spurious", 32'(a_out_valid), 32'd0);
        end else begin
          check("A_res", 32'({a_zero, a_ovf, a_cout, a_sum}), 32'(q_a[0].exp));
          if (a_out_ready) begin
            if (chk_lat) check("A_lat", 32'(cyc - q_a[0].t), NS_A);
            void'(q_a.pop_front());
          end
        end
      end
      if (a_in_valid && a_in_ready)
        q_a.push_back('{model(8, a_a, a_b, a_addsub), cyc + 1});
    end
  end

  always @(negedge clk) begin
    if (!nrst) begin
      q_b.delete();
    end else begin
      if (b_out_valid) begin
        if (q_b.size() == 0) begin
          check("B_spurious", 32'(b_out_valid), 32'd0);
        end else begin
          check("B_res", 32'({b_zero, b_ovf, b_cout, 1'b0, b_sum}), 32'(q_b[0].exp));
          if (b_out_ready) begin
            check("B_lat", 32'(cyc - q_b[0].t), NS_B);
            void'(q_b.pop_front());
          end
        end
      end
      if (b_in_valid && b_in_ready)
        q_b.push_back('{model(7, {1'b0, b_a}, {1'b0, b_b}, b_addsub), cyc + 1});
    end
  end

  // Present one operation and hold it until accepted; returns #1 after the capture edge.
  task automatic drive_a(logic sub, logic [7:0] x, logic [7:0] y);
    bit done = 1'b0;
    a_in_valid = 1'b1; a_addsub = sub; a_a = x; a_b = y;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = a_in_ready;
      @(posedge clk); #1;
    end
    if (!done) check("A_accept_timeout", 32'(done), 32'd1);
    a_in_valid = 1'b0;
  endtask

  task automatic drive_b(logic sub, logic [6:0] x, logic [6:0] y);
    bit done = 1'b0;
    b_in_valid = 1'b1; b_addsub = sub; b_a = x; b_b = y;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = b_in_ready;
      @(posedge clk); #1;
    end
    if (!done) check("B_accept_timeout", 32'(done), 32'd1);
    b_in_valid = 1'b0;
  endtask

  // Single operation into an empty pipeline, checked at its exact latency.
  task automatic op_a(logic sub, logic [7:0] x, logic [7:0] y, logic [10:0] exp);
    drive_a(sub, x, y);
    repeat (NS_A - 1) @(posedge clk);
    @(negedge clk); check("A_early", 32'(a_out_valid), 32'd0);
    @(negedge clk); check("A_valid", 32'(a_out_valid), 32'd1);
    check("A_direct", 32'({a_zero, a_ovf, a_cout, a_sum}), 32'(exp));
    @(posedge clk); #1;
  endtask

  task automatic op_b(logic sub, logic [6:0] x, logic [6:0] y, logic [10:0] exp);
    drive_b(sub, x, y);
    repeat (NS_B - 1) @(posedge clk);
    @(negedge clk); check("B_early", 32'(b_out_valid), 32'd0);
    @(negedge clk); check("B_valid", 32'(b_out_valid), 32'd1);
    check("B_direct", 32'({b_zero, b_ovf, b_cout, 1'b0, b_sum}), 32'(exp));
    @(posedge clk); #1;
  endtask

  task automatic drain_a();
    for (int i = 0; i < 200 && q_a.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    repeat (2) begin @(posedge clk); #1; end
    check("A_drain", 32'(q_a.size()), 32'd0);
  endtask

  task automatic drain_b();
    for (int i = 0; i < 200 && q_b.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    repeat (2) begin @(posedge clk); #1; end
    check("B_drain", 32'(q_b.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0;
    a_in_valid = 1'b0; a_addsub = 1'b0; a_a = '0; a_b = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_addsub = 1'b0; b_a = '0; b_b = '0; b_out_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check("A_rst_out", 32'({a_out_valid, a_zero, a_ovf, a_cout, a_sum}), 32'd0);
    check("A_rst_rdy", 32'(a_in_ready), 32'd1);
    check("B_rst_out", 32'({b_out_valid, b_zero, b_ovf, b_cout, b_sum}), 32'd0);
    check("B_rst_rdy", 32'(b_in_ready), 32'd1);
    @(posedge clk); #1 nrst = 1'b1;
    repeat (3) @(negedge clk);
    check("A_idle_vld", 32'(a_out_valid), 32'd0);
    check("A_idle_rdy", 32'(a_in_ready), 32'd1);
    check("B_idle_vld", 32'(b_out_valid), 32'd0);
    @(posedge clk); #1;

    // Directed additions and subtractions: {zero, ovf, cout, sum}.
    op_a(1'b0, 8'd100, 8'd100, {1'b0, 1'b1, 1'b0, 8'd200});
    op_a(1'b0, 8'd200, 8'd100, {1'b0, 1'b0, 1'b1, 8'd44});
    op_a(1'b1, 8'd5,   8'd7,   {1'b0, 1'b0, 1'b0, 8'hFE});
    op_a(1'b1, 8'd7,   8'd7,   {1'b1, 1'b0, 1'b1, 8'h00});
    op_a(1'b1, 8'h80,  8'h01,  {1'b0, 1'b1, 1'b1, 8'h7F});

    // Four mixed operations back to back; the monitor checks order and latency.
    drive_a(1'b0, 8'd1,   8'd2);
    drive_a(1'b1, 8'd0,   8'd1);
    drive_a(1'b0, 8'hFF,  8'h01);
    drive_a(1'b1, 8'h7F,  8'h80);
    drain_a();

    // Fill the pipeline with the output stalled, then release.
    chk_lat = 1'b0;
    a_out_ready = 1'b0;
    drive_a(1'b0, 8'd10, 8'd20);
    drive_a(1'b1, 8'd30, 8'd40);
    drive_a(1'b0, 8'h90, 8'h90);
    drive_a(1'b1, 8'd50, 8'd50);
    drive_a(1'b0, 8'h0F, 8'hF1);
    fork
      drive_a(1'b1, 8'h10, 8'h20);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("A_stall_rdy", 32'(a_in_ready), 32'd0);
          check("A_stall_vld", 32'(a_out_valid), 32'd1);
          check("A_stall_q", 32'(q_a.size()), 32'd5);
        end
        @(posedge clk); #1 a_out_ready = 1'b1;
      end
    join
    drain_a();

    // Random traffic with bubbles and random backpressure.
    rnd_on = 1'b1;
    fork
      while (rnd_on) begin
        @(posedge clk); #1;
        a_out_ready = 1'($urandom_range(0, 1));
      end
    join_none
    for (int i = 0; i < 60; i++) begin
      drive_a(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    end
    rnd_on = 1'b0;
    @(posedge clk); #2 a_out_ready = 1'b1;
    drain_a();
    chk_lat = 1'b1;

    // Three-stage instance: wrap to zero, then reset with a result in flight.
    op_b(1'b0, 7'd127, 7'd1, {1'b1, 1'b0, 1'b1, 8'h00});
    drive_b(1'b0, 7'd5, 7'd6);
    @(posedge clk); #1 nrst = 1'b0;
    @(negedge clk);
    check("B_rst_mid", 32'({b_out_valid, b_zero, b_ovf, b_cout, b_sum}), 32'd0);
    @(posedge clk); #1 nrst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("B_flush", 32'(b_out_valid), 32'd0);
    end
    @(posedge clk); #1;
    op_b(1'b1, 7'd3, 7'd5, {1'b0, 1'b0, 1'b0, 8'd126});
    for (int i = 0; i < 12; i++)
      drive_b(1'($urandom_range(0, 1)), 7'($urandom), 7'($urandom));
    drain_b();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
